dm_responder: RTL

Data-memory responder at the far end of the CPU's MEM-stage data interface. It takes write enable, address, write data and access type from the pipeline and returns load data combinationally in the same cycle. Sub-word stores are merged into word storage, and sub-word loads are sign- or zero-extended. A small MMIO window holds an LED register, a free-running cycle counter and sticky access-error status with an error counter.

---
 rtl/dm_pkg.sv | 32 +++
 rtl/dm_load_ext.sv | 26 ++
 rtl/dm_responder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - access type codes, MMIO map and STAT bit positions for dm_responder
package dm_pkg;

    typedef enum logic [2:0] {
        DM_W  = 3'b000,
        DM_H  = 3'b001,
        DM_HU = 3'b010,
        DM_B  = 3'b011,
        DM_BU = 3'b100
    } dm_type_e;

    // MMIO window is Addr_in[31:4] == MMIO_BASE_HI; registers indexed by Addr_in[3:2]
    localparam logic [27:0] MMIO_BASE_HI = 28'h8000000;
    localparam logic [1:0]  OFF_LED      = 2'd0;
    localparam logic [1:0]  OFF_CYC      = 2'd1;
    localparam logic [1:0]  OFF_STAT     = 2'd2;
    localparam logic [1:0]  OFF_ERRCNT   = 2'd3;

    localparam int STAT_MISALIGN = 0;
    localparam int STAT_OOR      = 1;

    function automatic dm_type_e dm_norm_type(input logic [2:0] code);
        case (code)
            3'b001:  return DM_H;
            3'b010:  return DM_HU;
            3'b011:  return DM_B;
            3'b100:  return DM_BU;
            default: return DM_W;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// rtl/dm_load_ext.sv - lane select and sign/zero extension of a 32-bit word for loads
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  dm_type_e    i_type,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_type)
            DM_B:    o_data = {{24{w_byte[7]}}, w_byte};
            DM_BU:   o_data = {24'd0, w_byte};
            DM_H:    o_data = {{16{w_half[15]}}, w_half};
            DM_HU:   o_data = {16'd0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: word RAM with sub-word merge, LED/CYC/STAT/ERRCNT MMIO
module dm_responder
    import dm_pkg::*;
#(
    parameter  int DEPTH_WORDS = 128,
    parameter  int ERRCNT_W    = 8,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mem_w,
    input  logic [31:0]   Addr_in,
    input  logic [31:0]   Data_in,
    input  logic [2:0]    DMType,
    output logic [31:0]   Data_out,
    output logic [15:0]   led_out,
    output logic          err_out,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    logic [31:0]         r_ram [DEPTH_WORDS];
    logic [15:0]         r_led;
    logic [31:0]         r_cyc;
    logic [1:0]          r_stat;
    logic [ERRCNT_W-1:0] r_errcnt;

    dm_type_e    w_type;
    logic        w_is_ram;
    logic        w_is_mmio;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic [AW-1:0] w_idx;
    logic [31:0] w_ram_word;
    logic [31:0] w_merged;
    logic [31:0] w_ram_load;
    logic [31:0] w_mmio_rd;
    logic        w_ram_we;
    logic        w_mmio_we;
    logic [1:0]  w_stat_set;
    logic [1:0]  w_stat_clr;
    logic [1:0]  w_stat_next;

    assign w_type     = dm_norm_type(DMType);
    assign w_is_ram   = (Addr_in[31:28] == 4'h0);
    assign w_is_mmio  = (Addr_in[31:4] == MMIO_BASE_HI);
    assign w_misalign = (((w_type == DM_H) || (w_type == DM_HU)) && Addr_in[0])
                      || ((w_type == DM_W) && (Addr_in[1:0] != 2'b00));
    assign w_oor      = w_is_ram && ({6'd0, Addr_in[27:2]} >= 32'(DEPTH_WORDS));
    assign w_err      = w_misalign || w_oor;

    assign w_idx      = Addr_in[AW+1:2];
    assign w_ram_word = r_ram[w_idx];
    assign dbg_data   = r_ram[dbg_addr];

    // Any error suppresses the store; MMIO accepts only full-word stores
    assign w_ram_we  = mem_w && !reset && w_is_ram && !w_err;
    assign w_mmio_we = mem_w && !reset && w_is_mmio && !w_err && (w_type == DM_W);

    always_comb begin
        w_merged = w_ram_word;
        case (w_type)
            DM_B, DM_BU: w_merged[{Addr_in[1:0], 3'b000} +: 8] = Data_in[7:0];
            DM_H, DM_HU: begin
                if (Addr_in[1]) w_merged[31:16] = Data_in[15:0];
                else            w_merged[15:0]  = Data_in[15:0];
            end
            default:     w_merged = Data_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_idx] <= w_merged;
    end

    assign w_stat_set  = {w_oor, w_misalign};
    assign w_stat_clr  = (w_mmio_we && (Addr_in[3:2] == OFF_STAT)) ? Data_in[1:0] : 2'b00;
    // A new error outranks a simultaneous write-1-to-clear of the same bit
    assign w_stat_next = (r_stat & ~w_stat_clr) | w_stat_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led    <= 16'd0;
            r_cyc    <= 32'd0;
            r_stat   <= 2'b00;
            r_errcnt <= '0;
        end else begin
            r_cyc  <= r_cyc + 32'd1;
            r_stat <= w_stat_next;
            if (w_mmio_we && (Addr_in[3:2] == OFF_LED)) r_led <= Data_in[15:0];
            if (w_err && (r_errcnt != '1)) r_errcnt <= r_errcnt + ERRCNT_W'(1);
        end
    end

    dm_load_ext u_ram_ext (
        .i_word (w_ram_word),
        .i_lane (Addr_in[1:0]),
        .i_type (w_type),
        .o_data (w_ram_load)
    );

    always_comb begin
        case (Addr_in[3:2])
            OFF_LED:  w_mmio_rd = {16'd0, r_led};
            OFF_CYC:  w_mmio_rd = r_cyc;
            OFF_STAT: w_mmio_rd = {30'd0, r_stat};
            default:  w_mmio_rd = 32'(r_errcnt);
        endcase
    end

    always_comb begin
        Data_out = 32'd0;
        if (!w_err) begin
            if (w_is_ram)       Data_out = w_ram_load;
            else if (w_is_mmio) Data_out = w_mmio_rd;
        end
    end

    assign led_out = r_led;
    assign err_out = |r_stat;

endmodule
